// File: rtl/cache_fill_arbiter_if.sv
// VRAM read-port bus between the cache fill arbiter and the memory controller.
// The arbiter issues a held read request; the controller acknowledges it and streams 32-bit beats back.
interface cache_fill_arbiter_if;
  logic        o_memReq;
  logic [17:0] o_memAdr;
  logic [7:0]  o_memLen;
  logic        i_memAck;
  logic        i_memDataValid;
  logic [31:0] i_memData;

  modport master (
    output o_memReq, o_memAdr, o_memLen,
    input  i_memAck, i_memDataValid, i_memData
  );

  modport slave (
    input  o_memReq, o_memAdr, o_memLen,
    output i_memAck, i_memDataValid, i_memData
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Shares one VRAM read port between the texture-cache and CLUT-cache fill requesters of both pixel lanes.
// Grants one fill at a time, streams the returned beats into the selected cache, then pulses completion.
module cache_fill_arbiter (
  input  logic                        clk,
  input  logic                        i_nrst,
  input  logic [1:0]                  GPU_REG_TexFormat,
  input  logic                        requTexCacheUpdateL,
  input  logic                        requTexCacheUpdateR,
  input  logic [16:0]                 adrTexCacheUpdateL,
  input  logic [16:0]                 adrTexCacheUpdateR,
  output logic                        updateTexCacheCompleteL,
  output logic                        updateTexCacheCompleteR,
  input  logic                        requClutCacheUpdateL,
  input  logic                        requClutCacheUpdateR,
  input  logic [19:0]                 adrClutCacheUpdateL,
  input  logic [19:0]                 adrClutCacheUpdateR,
  output logic                        updateClutCacheCompleteL,
  output logic                        updateClutCacheCompleteR,
  output logic                        TexCacheWrite,
  output logic [16:0]                 adrTexCacheWrite,
  output logic [63:0]                 TexCacheData,
  output logic                        ClutCacheWrite,
  output logic [6:0]                  ClutWriteIndex,
  output logic [31:0]                 ClutCacheData,
  cache_fill_arbiter_if.master        mem,
  output logic                        o_busy
);

  typedef enum logic [2:0] {
    IDLE, TEX_REQ, TEX_DATA, CLUT_REQ, CLUT_DATA, DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_rr;
  logic        r_fillTex;
  logic        r_ownL;
  logic        r_ownR;
  logic [17:0] r_memAdr;
  logic [7:0]  r_memLen;
  logic [6:0]  r_beatCnt;
  logic [6:0]  r_lastIdx;
  logic [16:0] r_texAdr;
  logic [63:0] r_texData;
  logic        r_clutWrite;
  logic [6:0]  r_clutIndex;
  logic [31:0] r_clutData;

  logic        w_texAny;
  logic        w_clutAny;
  logic        w_grant;
  logic        w_grantR;
  logic        w_coOwn;
  logic [16:0] w_selTexAdr;
  logic [19:0] w_selClutAdr;
  logic        w_beatValid;
  logic        w_lastBeat;
  logic        w_memReq;
  logic        w_unusedAdrBits;

  assign w_unusedAdrBits = &{adrClutCacheUpdateL[1:0], adrClutCacheUpdateR[1:0]};

  // Texture always wins over CLUT; within a type the round-robin pointer picks the side.
  always_comb begin
    w_texAny     = requTexCacheUpdateL | requTexCacheUpdateR;
    w_clutAny    = requClutCacheUpdateL | requClutCacheUpdateR;
    w_grant      = w_texAny | w_clutAny;
    w_grantR     = 1'b0;
    w_coOwn      = 1'b0;
    if (w_texAny) begin
      w_grantR = requTexCacheUpdateR & (~requTexCacheUpdateL | r_rr);
      w_coOwn  = requTexCacheUpdateL & requTexCacheUpdateR &
                 (adrTexCacheUpdateL == adrTexCacheUpdateR);
    end else begin
      w_grantR = requClutCacheUpdateR & (~requClutCacheUpdateL | r_rr);
      w_coOwn  = requClutCacheUpdateL & requClutCacheUpdateR &
                 (adrClutCacheUpdateL[19:2] == adrClutCacheUpdateR[19:2]);
    end
    w_selTexAdr  = w_grantR ? adrTexCacheUpdateR  : adrTexCacheUpdateL;
    w_selClutAdr = w_grantR ? adrClutCacheUpdateR : adrClutCacheUpdateL;
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState              = r_state;
    w_beatValid              = 1'b0;
    w_lastBeat               = 1'b0;
    w_memReq                 = 1'b0;
    o_busy                   = (r_state != IDLE);
    TexCacheWrite            = 1'b0;
    updateTexCacheCompleteL  = 1'b0;
    updateTexCacheCompleteR  = 1'b0;
    updateClutCacheCompleteL = 1'b0;
    updateClutCacheCompleteR = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) w_nextState = w_texAny ? TEX_REQ : CLUT_REQ;
      end
      TEX_REQ: begin
        w_memReq = 1'b1;
        if (mem.i_memAck) w_nextState = TEX_DATA;
      end
      TEX_DATA: begin
        w_beatValid = mem.i_memDataValid;
        w_lastBeat  = r_beatCnt[0];
        if (w_beatValid && w_lastBeat) w_nextState = DONE;
      end
      CLUT_REQ: begin
        w_memReq = 1'b1;
        if (mem.i_memAck) w_nextState = CLUT_DATA;
      end
      CLUT_DATA: begin
        w_beatValid = mem.i_memDataValid;
        w_lastBeat  = (r_beatCnt == r_lastIdx);
        if (w_beatValid && w_lastBeat) w_nextState = DONE;
      end
      DONE: begin
        w_nextState              = IDLE;
        TexCacheWrite            = r_fillTex;
        updateTexCacheCompleteL  = r_fillTex & r_ownL;
        updateTexCacheCompleteR  = r_fillTex & r_ownR;
        updateClutCacheCompleteL = ~r_fillTex & r_ownL;
        updateClutCacheCompleteR = ~r_fillTex & r_ownR;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Fill parameters are captured once at grant; beats then fill the line or stream CLUT entries.
  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_rr        <= 1'b0;
      r_fillTex   <= 1'b0;
      r_ownL      <= 1'b0;
      r_ownR      <= 1'b0;
      r_memAdr    <= '0;
      r_memLen    <= '0;
      r_beatCnt   <= '0;
      r_lastIdx   <= '0;
      r_texAdr    <= '0;
      r_texData   <= '0;
      r_clutWrite <= 1'b0;
      r_clutIndex <= '0;
      r_clutData  <= '0;
    end else begin
      r_clutWrite <= 1'b0;
      if (r_state == IDLE && w_grant) begin
        r_fillTex <= w_texAny;
        r_ownL    <= ~w_grantR | w_coOwn;
        r_ownR    <= w_grantR | w_coOwn;
        r_rr      <= ~w_grantR;
        r_beatCnt <= '0;
        if (w_texAny) begin
          r_texAdr <= w_selTexAdr;
          r_memAdr <= {w_selTexAdr, 1'b0};
          r_memLen <= 8'd2;
        end else begin
          r_memAdr  <= w_selClutAdr[19:2];
          r_memLen  <= (GPU_REG_TexFormat == 2'd0) ? 8'd8 : 8'd128;
          r_lastIdx <= (GPU_REG_TexFormat == 2'd0) ? 7'd7 : 7'd127;
        end
      end
      if (w_beatValid) begin
        r_beatCnt <= r_beatCnt + 7'd1;
        if (r_state == TEX_DATA) begin
          if (r_beatCnt[0]) r_texData[63:32] <= mem.i_memData;
          else              r_texData[31:0]  <= mem.i_memData;
        end else begin
          r_clutWrite <= 1'b1;
          r_clutIndex <= r_beatCnt;
          r_clutData  <= mem.i_memData;
        end
      end
    end
  end

  assign mem.o_memReq   = w_memReq;
  assign mem.o_memAdr   = r_memAdr;
  assign mem.o_memLen   = r_memLen;
  assign adrTexCacheWrite = r_texAdr;
  assign TexCacheData   = r_texData;
  assign ClutCacheWrite = r_clutWrite;
  assign ClutWriteIndex = r_clutIndex;
  assign ClutCacheData  = r_clutData;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: the bench plays the memory controller and checks
// grants, addresses, cache writes and completion pulses against hand-computed values.
`timescale 1ns/1ps
module tb_cache_fill_arbiter;
  logic        clk;
  logic        i_nrst;
  logic [1:0]  GPU_REG_TexFormat;
  logic        requTexCacheUpdateL, requTexCacheUpdateR;
  logic [16:0] adrTexCacheUpdateL, adrTexCacheUpdateR;
  logic        updateTexCacheCompleteL, updateTexCacheCompleteR;
  logic        requClutCacheUpdateL, requClutCacheUpdateR;
  logic [19:0] adrClutCacheUpdateL, adrClutCacheUpdateR;
  logic        updateClutCacheCompleteL, updateClutCacheCompleteR;
  logic        TexCacheWrite;
  logic [16:0] adrTexCacheWrite;
  logic [63:0] TexCacheData;
  logic        ClutCacheWrite;
  logic [6:0]  ClutWriteIndex;
  logic [31:0] ClutCacheData;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  cache_fill_arbiter_if memIf();

  cache_fill_arbiter dut (
    .clk                      (clk),
    .i_nrst                   (i_nrst),
    .GPU_REG_TexFormat        (GPU_REG_TexFormat),
    .requTexCacheUpdateL      (requTexCacheUpdateL),
    .requTexCacheUpdateR      (requTexCacheUpdateR),
    .adrTexCacheUpdateL       (adrTexCacheUpdateL),
    .adrTexCacheUpdateR       (adrTexCacheUpdateR),
    .updateTexCacheCompleteL  (updateTexCacheCompleteL),
    .updateTexCacheCompleteR  (updateTexCacheCompleteR),
    .requClutCacheUpdateL     (requClutCacheUpdateL),
    .requClutCacheUpdateR     (requClutCacheUpdateR),
    .adrClutCacheUpdateL      (adrClutCacheUpdateL),
    .adrClutCacheUpdateR      (adrClutCacheUpdateR),
    .updateClutCacheCompleteL (updateClutCacheCompleteL),
    .updateClutCacheCompleteR (updateClutCacheCompleteR),
    .TexCacheWrite            (TexCacheWrite),
    .adrTexCacheWrite         (adrTexCacheWrite),
    .TexCacheData             (TexCacheData),
    .ClutCacheWrite           (ClutCacheWrite),
    .ClutWriteIndex           (ClutWriteIndex),
    .ClutCacheData            (ClutCacheData),
    .mem                      (memIf.master),
    .o_busy                   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic tL, input logic tR, input logic cL, input logic cR,
                               input logic [16:0] aTL, input logic [16:0] aTR,
                               input logic [19:0] aCL, input logic [19:0] aCR,
                               input logic [1:0] fmt);
    requTexCacheUpdateL  = tL;
    requTexCacheUpdateR  = tR;
    requClutCacheUpdateL = cL;
    requClutCacheUpdateR = cR;
    adrTexCacheUpdateL   = aTL;
    adrTexCacheUpdateR   = aTR;
    adrClutCacheUpdateL  = aCL;
    adrClutCacheUpdateR  = aCR;
    GPU_REG_TexFormat    = fmt;
  endtask

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (memIf.o_memReq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) checkOutput("memReqTimeout", 64'd0, 64'd1);
  endtask

  // Serves one texture fill with back-to-back beats; returns in the DONE cycle.
  task automatic runTexFill(input logic [16:0] expAdr, input logic [31:0] lo, input logic [31:0] hi,
                            input logic expL, input logic expR);
    bit ok;
    waitReq(ok);
    if (!ok) return;
    checkOutput("texMemAdr", memIf.o_memAdr, {expAdr, 1'b0});
    checkOutput("texMemLen", memIf.o_memLen, 64'd2);
    memIf.i_memAck = 1'b1;
    tick();
    memIf.i_memAck = 1'b0;
    checkOutput("texReqDropped", memIf.o_memReq, 64'd0);
    memIf.i_memDataValid = 1'b1;
    memIf.i_memData      = lo;
    tick();
    memIf.i_memData      = hi;
    tick();
    memIf.i_memDataValid = 1'b0;
    checkOutput("texWrite", TexCacheWrite, 64'd1);
    checkOutput("texData", TexCacheData, {hi, lo});
    checkOutput("texWrAdr", adrTexCacheWrite, expAdr);
    checkOutput("texCompL", updateTexCacheCompleteL, expL);
    checkOutput("texCompR", updateTexCacheCompleteR, expR);
    checkOutput("texClutCompL", updateClutCacheCompleteL, 64'd0);
  endtask

  // Serves one CLUT fill, optionally pausing one cycle after beat gapAt; returns in the DONE cycle.
  task automatic runClutFill(input logic [17:0] expAdr, input int beats,
                             input logic expL, input logic expR, input int gapAt);
    bit ok;
    int errs;
    waitReq(ok);
    if (!ok) return;
    checkOutput("clutMemAdr", memIf.o_memAdr, expAdr);
    checkOutput("clutMemLen", memIf.o_memLen, beats);
    memIf.i_memAck = 1'b1;
    tick();
    memIf.i_memAck = 1'b0;
    for (int k = 0; k < beats; k++) begin
      memIf.i_memDataValid = 1'b1;
      memIf.i_memData      = 32'hC0DE_0000 + k;
      tick();
      memIf.i_memDataValid = 1'b0;
      checkOutput("clutWrite", ClutCacheWrite, 64'd1);
      checkOutput("clutIndex", ClutWriteIndex, k);
      checkOutput("clutData", ClutCacheData, 32'hC0DE_0000 + k);
      checkOutput("clutCompL", updateClutCacheCompleteL, (k == beats - 1) ? expL : 1'b0);
      checkOutput("clutCompR", updateClutCacheCompleteR, (k == beats - 1) ? expR : 1'b0);
      if (k == gapAt) begin
        tick();
        checkOutput("clutGapNoWrite", ClutCacheWrite, 64'd0);
      end
    end
    errs = 0;
    if (TexCacheWrite !== 1'b0) errs++;
    checkOutput("clutNoTexWrite", errs, 64'd0);
  endtask

  task automatic doReset();
    i_nrst = 1'b0;
    repeat (2) tick();
    i_nrst = 1'b1;
    tick();
  endtask

  initial begin
    bit ok;
    i_nrst = 1'b0;
    memIf.i_memAck       = 1'b0;
    memIf.i_memDataValid = 1'b0;
    memIf.i_memData      = '0;
    applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, 2'd0);
    doReset();

    checkOutput("rstBusy", o_busy, 64'd0);
    checkOutput("rstMemReq", memIf.o_memReq, 64'd0);
    checkOutput("rstTexData", TexCacheData, 64'd0);
    checkOutput("rstClutWrite", ClutCacheWrite, 64'd0);

    $display("[TB] single texture fill, left");
    applyStimulus(1, 0, 0, 0, 17'h1ABCD, '0, '0, '0, 2'd0);
    checkOutput("idleBusy", o_busy, 64'd0);
    tick();
    checkOutput("reqLatency", memIf.o_memReq, 64'd1);
    checkOutput("texMemAdrConst", memIf.o_memAdr, 64'h3579A);
    runTexFill(17'h1ABCD, 32'h1111_2222, 32'h3333_4444, 1, 0);
    checkOutput("doneBusy", o_busy, 64'd1);
    applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, 2'd0);
    tick();
    checkOutput("pulseEndWrite", TexCacheWrite, 64'd0);
    checkOutput("pulseEndComp", updateTexCacheCompleteL, 64'd0);
    checkOutput("backIdle", o_busy, 64'd0);

    $display("[TB] texture round robin");
    doReset();
    applyStimulus(1, 1, 0, 0, 17'h00100, 17'h00200, '0, '0, 2'd0);
    tick();
    runTexFill(17'h00100, 32'hA0A0_0001, 32'hA0A0_0002, 1, 0);
    requTexCacheUpdateL = 1'b0;
    tick();
    checkOutput("rrIdleGap", memIf.o_memReq, 64'd0);
    tick();
    runTexFill(17'h00200, 32'hB0B0_0001, 32'hB0B0_0002, 0, 1);
    applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, 2'd0);
    tick();
    applyStimulus(1, 1, 0, 0, 17'h00300, 17'h00400, '0, '0, 2'd0);
    tick();
    runTexFill(17'h00300, 32'hC0C0_0001, 32'hC0C0_0002, 1, 0);
    requTexCacheUpdateL = 1'b0;
    tick();
    runTexFill(17'h00400, 32'hD0D0_0001, 32'hD0D0_0002, 0, 1);
    applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, 2'd0);
    tick();

    $display("[TB] coalesced texture fill");
    applyStimulus(1, 1, 0, 0, 17'h00040, 17'h00040, '0, '0, 2'd0);
    tick();
    runTexFill(17'h00040, 32'h5555_6666, 32'h7777_8888, 1, 1);
    applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, 2'd0);
    tick();
    tick();
    checkOutput("coalesceNoSecondReq", memIf.o_memReq, 64'd0);

    $display("[TB] CLUT fills, 4bpp then 8bpp");
    applyStimulus(0, 0, 0, 1, '0, '0, '0, 20'h12344, 2'd0);
    tick();
    runClutFill(18'h048D1, 8, 0, 1, -1);
    requClutCacheUpdateR = 1'b0;
    tick();
    checkOutput("clutEndWrite", ClutCacheWrite, 64'd0);
    applyStimulus(0, 0, 0, 1, '0, '0, '0, 20'h12344, 2'd1);
    tick();
    runClutFill(18'h048D1, 128, 0, 1, 60);
    requClutCacheUpdateR = 1'b0;
    tick();

    $display("[TB] texture beats CLUT");
    applyStimulus(1, 0, 0, 1, 17'h0F00F, '0, '0, 20'h00020, 2'd0);
    tick();
    runTexFill(17'h0F00F, 32'h0102_0304, 32'h0506_0708, 1, 0);
    requTexCacheUpdateL = 1'b0;
    tick();
    checkOutput("clutAfterTexIdle", memIf.o_memReq, 64'd0);
    tick();
    checkOutput("clutAfterTexReq", memIf.o_memReq, 64'd1);
    runClutFill(18'h00008, 8, 0, 1, 3);
    requClutCacheUpdateR = 1'b0;
    tick();

    $display("[TB] asynchronous reset mid CLUT fill");
    applyStimulus(0, 0, 0, 1, '0, '0, '0, 20'h0ABC8, 2'd1);
    tick();
    waitReq(ok);
    checkOutput("rstFillAdr", memIf.o_memAdr, 64'h02AF2);
    memIf.i_memAck = 1'b1;
    tick();
    memIf.i_memAck = 1'b0;
    for (int k = 0; k < 50; k++) begin
      memIf.i_memDataValid = 1'b1;
      memIf.i_memData      = 32'hBEEF_0000 + k;
      tick();
    end
    checkOutput("preRstIndex", ClutWriteIndex, 64'd49);
    memIf.i_memData = 32'hBEEF_0032;
    #2;
    i_nrst = 1'b0;
    #1;
    checkOutput("asyncClutWrite", ClutCacheWrite, 64'd0);
    checkOutput("asyncClutIndex", ClutWriteIndex, 64'd0);
    checkOutput("asyncClutData", ClutCacheData, 64'd0);
    checkOutput("asyncMemReq", memIf.o_memReq, 64'd0);
    checkOutput("asyncMemAdr", memIf.o_memAdr, 64'd0);
    checkOutput("asyncBusy", o_busy, 64'd0);
    memIf.i_memDataValid = 1'b0;
    #2;
    i_nrst = 1'b1;
    memIf.i_memDataValid = 1'b1;
    memIf.i_memData      = 32'hDEAD_DEAD;
    tick();
    checkOutput("strayIdleNoWrite", ClutCacheWrite, 64'd0);
    checkOutput("restartReq", memIf.o_memReq, 64'd1);
    tick();
    checkOutput("strayReqNoWrite", ClutCacheWrite, 64'd0);
    memIf.i_memDataValid = 1'b0;
    runClutFill(18'h02AF2, 128, 0, 1, -1);
    requClutCacheUpdateR = 1'b0;
    tick();

    applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, 2'd0);
    memIf.i_memDataValid = 1'b1;
    tick();
    tick();
    checkOutput("idleStrayWrite", ClutCacheWrite, 64'd0);
    checkOutput("idleStrayBusy", o_busy, 64'd0);
    memIf.i_memDataValid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
